// File: rtl/dcs_seq_ctrl.sv
// Sequencer that streams 128 input bytes and 8 weight bytes from memory into the DCS
// accelerator and collects its 8 results. `DCS_SEQ_PERF_EN adds a busy-cycle counter.
`timescale 1ns/1ps
module dcs_seq_ctrl #(
    parameter int TIMEOUT = 1023,
    parameter int W_BASE  = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        mem_rd_en,
    output logic [7:0]  mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        dcs_i_valid,
    output logic [7:0]  dcs_i_data,
    output logic        dcs_w_valid,
    output logic [7:0]  dcs_w_data,
    input  logic        dcs_w_ready,
    input  logic        dcs_o_valid,
    input  logic [31:0] dcs_o_data,
    output logic        res_valid,
    output logic [2:0]  res_idx,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef DCS_SEQ_PERF_EN
   ,output logic [15:0] perf_cycles
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_I = 3'd1;
    localparam logic [2:0] S_WAIT_WR = 3'd2;
    localparam logic [2:0] S_FETCH_W = 3'd3;
    localparam logic [2:0] S_WAIT_O  = 3'd4;

    localparam logic [9:0] LP_TO = TIMEOUT[9:0];
    localparam logic [7:0] LP_WB = W_BASE[7:0];

    logic [2:0]  r_state;
    logic [6:0]  r_cnt;
    logic [9:0]  r_idle;
    logic [2:0]  r_beat;
    logic        r_wr_pend;
    logic        r_i_valid;
    logic        r_w_valid;
    logic        r_res_valid;
    logic [2:0]  r_res_idx;
    logic [31:0] r_res_data;
    logic        r_done;
    logic        r_err;

    logic        w_fetch_i;
    logic        w_fetch_w;
    logic        w_busy;
    logic        w_idle_hit;
    logic        w_accept;

    assign w_fetch_i  = (r_state == S_FETCH_I);
    assign w_fetch_w  = (r_state == S_FETCH_W);
    assign w_busy     = (r_state != S_IDLE);
    assign w_idle_hit = (r_idle == LP_TO);
    assign w_accept   = (r_state == S_IDLE) && start;

    assign mem_rd_en  = w_fetch_i | w_fetch_w;
    assign mem_addr   = w_fetch_i ? {1'b0, r_cnt} :
                        w_fetch_w ? (LP_WB + {5'd0, r_cnt[2:0]}) : 8'd0;

    // Read data is forwarded straight through, gated so idle/reset shows zero
    assign dcs_i_valid = r_i_valid;
    assign dcs_i_data  = r_i_valid ? mem_rdata : 8'd0;
    assign dcs_w_valid = r_w_valid;
    assign dcs_w_data  = r_w_valid ? mem_rdata : 8'd0;

    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_data  = r_res_data;
    assign busy      = w_busy;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            r_idle      <= 10'd0;
            r_beat      <= 3'd0;
            r_wr_pend   <= 1'b0;
            r_i_valid   <= 1'b0;
            r_w_valid   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_idx   <= 3'd0;
            r_res_data  <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_i_valid   <= w_fetch_i;
            r_w_valid   <= w_fetch_w;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH_I;
                        r_cnt     <= 7'd0;
                        r_beat    <= 3'd0;
                        r_wr_pend <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                S_FETCH_I: begin
                    r_cnt <= r_cnt + 7'd1;
                    if (dcs_w_ready)
                        r_wr_pend <= 1'b1;
                    if (r_cnt == 7'd127) begin
                        r_state <= S_WAIT_WR;
                        r_idle  <= 10'd0;
                    end
                end
                S_WAIT_WR: begin
                    if (r_wr_pend || dcs_w_ready) begin
                        r_state   <= S_FETCH_W;
                        r_cnt     <= 7'd0;
                        r_wr_pend <= 1'b0;
                    end else if (w_idle_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idle <= r_idle + 10'd1;
                    end
                end
                S_FETCH_W: begin
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt[2:0] == 3'd7) begin
                        r_state <= S_WAIT_O;
                        r_idle  <= 10'd0;
                    end
                end
                S_WAIT_O: begin
                    // Stay busy through the done cycle, leave on the next edge
                    if (r_done) begin
                        r_state <= S_IDLE;
                    end else if (dcs_o_valid) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= dcs_o_data;
                        r_res_idx   <= r_beat;
                        r_beat      <= r_beat + 3'd1;
                        r_idle      <= 10'd0;
                        if (r_beat == 3'd7)
                            r_done <= 1'b1;
                    end else if (w_idle_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idle <= r_idle + 10'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DCS_SEQ_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_perf <= 16'd0;
        else if (w_accept)
            r_perf <= 16'd0;
        else if (w_busy && (r_perf != 16'hFFFF))
            r_perf <= r_perf + 16'd1;
    end

    assign perf_cycles = r_perf;
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_dcs_seq_ctrl.sv
// Directed bench for dcs_seq_ctrl: memory and accelerator are modelled inline,
// expected values are hand-derived cycle by cycle.
`timescale 1ns/1ps
module tb_dcs_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic        dcs_i_valid;
    logic [7:0]  dcs_i_data;
    logic        dcs_w_valid;
    logic [7:0]  dcs_w_data;
    logic        dcs_w_ready;
    logic        dcs_o_valid;
    logic [31:0] dcs_o_data;
    logic        res_valid;
    logic [2:0]  res_idx;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic        err;
`ifdef DCS_SEQ_PERF_EN
    logic [15:0] perf_cycles;
`endif

    logic [7:0] mem [256];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int s_cyc;
    int d_cyc;

    dcs_seq_ctrl #(.TIMEOUT(16), .W_BASE(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dcs_i_valid(dcs_i_valid), .dcs_i_data(dcs_i_data),
        .dcs_w_valid(dcs_w_valid), .dcs_w_data(dcs_w_data),
        .dcs_w_ready(dcs_w_ready), .dcs_o_valid(dcs_o_valid),
        .dcs_o_data(dcs_o_data), .res_valid(res_valid), .res_idx(res_idx),
        .res_data(res_data), .busy(busy), .done(done), .err(err)
`ifdef DCS_SEQ_PERF_EN
       ,.perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered on FETCH_I cycle 0; leaves on the cycle of the last i beat
    task automatic fetch_i();
        for (int k = 0; k < 128; k++) begin
            chk("fi_rd", 32'(mem_rd_en), 32'd1);
            chk("fi_addr", 32'(mem_addr), 32'(k));
            chk("fi_iv", 32'(dcs_i_valid), 32'(k > 0));
            if (k > 0)
                chk("fi_id", 32'(dcs_i_data), 32'(k - 1));
            chk("fi_wv", 32'(dcs_w_valid), 32'd0);
            chk("fi_rv", 32'(res_valid), 32'd0);
            tick();
        end
        chk("fi_rd_end", 32'(mem_rd_en), 32'd0);
        chk("fi_iv_last", 32'(dcs_i_valid), 32'd1);
        chk("fi_id_last", 32'(dcs_i_data), 32'd127);
    endtask

    // Entered on FETCH_W cycle 0; leaves on the cycle of the last w beat
    task automatic fetch_w();
        for (int j = 0; j < 9; j++) begin
            chk("fw_rd", 32'(mem_rd_en), 32'(j < 8));
            if (j < 8)
                chk("fw_addr", 32'(mem_addr), 32'(128 + j));
            chk("fw_wv", 32'(dcs_w_valid), 32'(j > 0));
            if (j > 0)
                chk("fw_wd", 32'(dcs_w_data), 32'(127 + j));
            chk("fw_iv", 32'(dcs_i_valid), 32'd0);
            if (j < 8)
                tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 8'(i);
        rst_n = 1'b0;
        start = 1'b0;
        dcs_w_ready = 1'b0;
        dcs_o_valid = 1'b0;
        dcs_o_data = 32'd0;
        tick();
        tick();
        chk("rst_flags", 32'({mem_rd_en, dcs_i_valid, dcs_w_valid, res_valid,
                              done, err, busy}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdata", res_data, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Job A: stray o_valid and start while busy must be ignored
        start = 1'b1;
        s_cyc = cyc;
        tick();
        chk("a_busy", 32'(busy), 32'd1);
        dcs_o_valid = 1'b1;
        dcs_o_data = 32'hDEADBEEF;
        fetch_i();
        start = 1'b0;
        dcs_o_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_wait_wv", 32'(dcs_w_valid), 32'd0);
            chk("a_wait_iv", 32'(dcs_i_valid), 32'd0);
            chk("a_wait_rv", 32'(res_valid), 32'd0);
        end
        dcs_w_ready = 1'b1;
        tick();
        dcs_w_ready = 1'b0;
        fetch_w();
        for (int b = 0; b < 8; b++) begin
            dcs_o_valid = 1'b1;
            dcs_o_data = 32'(100 + b);
            tick();
            chk("a_rv", 32'(res_valid), 32'd1);
            chk("a_idx", 32'(res_idx), 32'(b));
            chk("a_data", res_data, 32'(100 + b));
            chk("a_done", 32'(done), 32'(b == 7));
            chk("a_busy_o", 32'(busy), 32'd1);
        end
        dcs_o_valid = 1'b0;
        start = 1'b1;
        d_cyc = cyc;
        tick();
        start = 1'b0;
        chk("a_end_busy", 32'(busy), 32'd0);
        chk("a_end_done", 32'(done), 32'd0);
        chk("a_end_rv", 32'(res_valid), 32'd0);
`ifdef DCS_SEQ_PERF_EN
        chk("a_perf", 32'(perf_cycles), 32'(d_cyc - s_cyc));
`endif
        tick();
        chk("a_start_ign", 32'(busy), 32'd0);

        // Job B: no w_ready, timeout after 16 idle cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        fetch_i();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("b_err0", 32'(err), 32'd0);
            chk("b_busy", 32'(busy), 32'd1);
            chk("b_wv", 32'(dcs_w_valid), 32'd0);
        end
        tick();
        chk("b_err1", 32'(err), 32'd1);
        chk("b_busy0", 32'(busy), 32'd0);
        chk("b_done0", 32'(done), 32'd0);
        tick();
        chk("b_err_sticky", 32'(err), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_err_clr", 32'(err), 32'd0);
        chk("b_restart", 32'(busy), 32'd1);

        // Job C: reset during FETCH_I beat 60
        repeat (61) tick();
        chk("c_iv60", 32'(dcs_i_valid), 32'd1);
        chk("c_id60", 32'(dcs_i_data), 32'd60);
        rst_n = 1'b0;
        #1;
        chk("c_rst_flags", 32'({mem_rd_en, dcs_i_valid, dcs_w_valid, res_valid,
                                done, err, busy}), 32'd0);
        chk("c_rst_addr", 32'(mem_addr), 32'd0);
        chk("c_rst_id", 32'(dcs_i_data), 32'd0);
        chk("c_rst_rdata", res_data, 32'd0);
        chk("c_rst_idx", 32'(res_idx), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c_post_iv", 32'(dcs_i_valid), 32'd0);
            chk("c_post_busy", 32'(busy), 32'd0);
            chk("c_post_rd", 32'(mem_rd_en), 32'd0);
        end

        // Job D: clean job, w_ready on the last i beat, results with gaps
        start = 1'b1;
        tick();
        start = 1'b0;
        fetch_i();
        dcs_w_ready = 1'b1;
        tick();
        dcs_w_ready = 1'b0;
        fetch_w();
        for (int b = 0; b < 8; b++) begin
            dcs_o_valid = 1'b1;
            dcs_o_data = 32'hA5000000 + 32'(b);
            tick();
            dcs_o_valid = 1'b0;
            chk("d_rv", 32'(res_valid), 32'd1);
            chk("d_idx", 32'(res_idx), 32'(b));
            chk("d_data", res_data, 32'hA5000000 + 32'(b));
            chk("d_done", 32'(done), 32'(b == 7));
            if (b < 7) begin
                tick();
                chk("d_gap_rv", 32'(res_valid), 32'd0);
                chk("d_gap_done", 32'(done), 32'd0);
            end
        end
        tick();
        chk("d_end_busy", 32'(busy), 32'd0);
        chk("d_end_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
